// File: rtl/idma_obi_mem_responder_pkg.sv
// Shared defaults and sizing helpers for the OBI-to-memory responder.
// Holds no state; imported by the interface, the response buffer and the top.
package idma_obi_mem_responder_pkg;

  localparam int unsigned DefDataWidth      = 32;
  localparam int unsigned DefAddrWidth      = 32;
  localparam int unsigned DefMemLatency     = 1;
  localparam int unsigned DefMaxOutstanding = 2;

  // Bits needed to hold a count of 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idma_obi_mem_responder_if.sv
// OBI A/R channel bundle between a manager and the memory responder.
//   A channel: obi_a_req_i, obi_a_addr_i, obi_a_we_i, obi_a_be_i, obi_a_wdata_i -> obi_a_gnt_o
//   R channel: obi_r_valid_o, obi_r_rdata_o <- obi_r_ready_i
// Signal suffixes are from the responder's point of view.
// slave modport: responder side; master modport: manager side.
interface idma_obi_mem_responder_if
  import idma_obi_mem_responder_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefAddrWidth
) ();

  logic                   obi_a_req_i;
  logic [AddrWidth-1:0]   obi_a_addr_i;
  logic                   obi_a_we_i;
  logic [DataWidth/8-1:0] obi_a_be_i;
  logic [DataWidth-1:0]   obi_a_wdata_i;
  logic                   obi_a_gnt_o;
  logic                   obi_r_valid_o;
  logic [DataWidth-1:0]   obi_r_rdata_o;
  logic                   obi_r_ready_i;

  modport slave (
    input  obi_a_req_i, obi_a_addr_i, obi_a_we_i, obi_a_be_i, obi_a_wdata_i, obi_r_ready_i,
    output obi_a_gnt_o, obi_r_valid_o, obi_r_rdata_o
  );

  modport master (
    output obi_a_req_i, obi_a_addr_i, obi_a_we_i, obi_a_be_i, obi_a_wdata_i, obi_r_ready_i,
    input  obi_a_gnt_o, obi_r_valid_o, obi_r_rdata_o
  );

endinterface

// File: rtl/idma_obi_rsp_buffer.sv
// Response FIFO for the OBI responder. Registered head (not fall-through):
// a pushed word becomes visible on rdata the cycle after the push.
// Ports: clk, rst (sync, active high), push/wdata, pop/rdata, full, empty.
// A push and a pop in the same cycle both take effect, also when full.
module idma_obi_rsp_buffer
  import idma_obi_mem_responder_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  logic [Depth-1:0][Width-1:0] storage;
  logic [PtrW-1:0]             wptr, rptr;
  logic [CntW-1:0]             count;
  logic                        push_ok, pop_ok;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = storage[rptr];

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        storage[wptr] <= wdata;
        wptr          <= nxt(wptr);
      end
      if (pop_ok) rptr <= nxt(rptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idma_obi_mem_responder.sv
// OBI subordinate that forwards requests to a fixed-latency memory and
// returns responses in grant order through a small FIFO.
// Ports: clk_i, rst_i (sync, active high); obi (slave modport: A/R channels);
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o to memory,
//   mem_rdata_i from memory, valid MemLatency cycles after mem_req_o.
// Outstanding count covers everything granted and not yet popped, so the
// buffer (depth MaxOutstanding) can never overflow.
module idma_obi_mem_responder
  import idma_obi_mem_responder_pkg::*;
#(
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned AddrWidth      = DefAddrWidth,
  parameter int unsigned MemLatency     = DefMemLatency,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  idma_obi_mem_responder_if.slave obi,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrWidth-1:0]    mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  logic [CntW-1:0]       outstanding;
  logic                  gnt, pop, push, empty, full, valid;
  logic [DataWidth-1:0]  push_data, head;
  // Stage 0 is the grant cycle itself; stage MemLatency is the data cycle.
  logic [MemLatency:0]   vld_pipe, we_pipe;
  logic [MemLatency:1]   vld_q, we_q;

  assign gnt = obi.obi_a_req_i && (outstanding < CntW'(MaxOutstanding)) && !rst_i;

  assign mem_req_o   = gnt;
  assign mem_we_o    = obi.obi_a_we_i;
  assign mem_addr_o  = obi.obi_a_addr_i;
  assign mem_be_o    = obi.obi_a_be_i;
  assign mem_wdata_o = obi.obi_a_wdata_i;

  assign vld_pipe = {vld_q, gnt};
  assign we_pipe  = {we_q, obi.obi_a_we_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q <= vld_pipe[MemLatency-1:0];
      we_q  <= we_pipe[MemLatency-1:0];
    end
  end

  assign push      = vld_pipe[MemLatency];
  assign push_data = we_pipe[MemLatency] ? '0 : mem_rdata_i;

  idma_obi_rsp_buffer #(
    .Width (DataWidth),
    .Depth (MaxOutstanding)
  ) i_rsp_buffer (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Gated by reset so the R channel is quiet even in the first reset cycle.
  assign valid             = !empty && !rst_i;
  assign pop               = valid && obi.obi_r_ready_i;
  assign obi.obi_a_gnt_o   = gnt;
  assign obi.obi_r_valid_o = valid;
  assign obi.obi_r_rdata_o = valid ? head : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({gnt, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_idma_obi_mem_responder.sv
// Bench for idma_obi_mem_responder: directed vectors, scoreboard queues filled
// at grant time and drained by per-DUT monitors on each R handshake.
// dut: MemLatency=1 MaxOutstanding=2; dut3: MemLatency=1 MaxOutstanding=3.
module tb_idma_obi_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];

  idma_obi_mem_responder_if #(.DataWidth(32), .AddrWidth(32)) a ();
  idma_obi_mem_responder_if #(.DataWidth(32), .AddrWidth(32)) b ();

  logic        mem_req2, mem_we2, mem_req3, mem_we3;
  logic [31:0] mem_addr2, mem_wdata2, mem_addr3, mem_wdata3;
  logic [3:0]  mem_be2, mem_be3;
  logic [31:0] mem_rdata2 = '0;
  logic [31:0] mem_rdata3 = '0;

  idma_obi_mem_responder #(.DataWidth(32), .AddrWidth(32), .MemLatency(1), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst), .obi(a),
    .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
    .mem_be_o(mem_be2), .mem_wdata_o(mem_wdata2), .mem_rdata_i(mem_rdata2)
  );

  idma_obi_mem_responder #(.DataWidth(32), .AddrWidth(32), .MemLatency(1), .MaxOutstanding(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .obi(b),
    .mem_req_o(mem_req3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
    .mem_be_o(mem_be3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  // Memory models, one cycle latency. Contents: 0x10 -> DEADBEEF, else 5A5A_<addr[15:0]>.
  function automatic logic [31:0] mem_f(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'hDEADBEEF : {16'h5A5A, addr[15:0]};
  endfunction

  always @(posedge clk) if (mem_req2 && !mem_we2) mem_rdata2 <= mem_f(mem_addr2);
  always @(posedge clk) if (mem_req3 && !mem_we3) mem_rdata3 <= mem_f(mem_addr3);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: sample away from the active edge; a handshake seen here pops at the next posedge.
  always @(negedge clk) begin
    if (a.obi_r_valid_o && a.obi_r_ready_i) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp2_unexpected: got %0h expected none", a.obi_r_rdata_o);
      end else chk("rsp2_data", a.obi_r_rdata_o, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b.obi_r_valid_o && b.obi_r_ready_i) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp3_unexpected: got %0h expected none", b.obi_r_rdata_o);
      end else chk("rsp3_data", b.obi_r_rdata_o, q3.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic rd2(input logic [31:0] addr);
    a.obi_a_req_i = 1'b1; a.obi_a_we_i = 1'b0; a.obi_a_addr_i = addr; a.obi_a_be_i = 4'hF;
  endtask

  logic [31:0] thr_exp [8] = '{32'h5A5A0300, 32'h5A5A0304, 32'h5A5A0308, 32'h5A5A030C,
                               32'h5A5A0310, 32'h5A5A0314, 32'h5A5A0318, 32'h5A5A031C};

  initial begin
    a.obi_a_req_i = 1'b1; a.obi_a_addr_i = 32'h10; a.obi_a_we_i = 1'b0;
    a.obi_a_be_i = 4'hF; a.obi_a_wdata_i = '0; a.obi_r_ready_i = 1'b1;
    b.obi_a_req_i = 1'b0; b.obi_a_addr_i = '0; b.obi_a_we_i = 1'b0;
    b.obi_a_be_i = 4'hF; b.obi_a_wdata_i = '0; b.obi_r_ready_i = 1'b1;

    // Reset: outputs quiet even with a request pending.
    cyc(); cyc();
    smp();
    chk("rst_gnt", a.obi_a_gnt_o, 0);
    chk("rst_valid", a.obi_r_valid_o, 0);
    chk("rst_memreq", mem_req2, 0);
    chk("rst_rdata", a.obi_r_rdata_o, 0);
    cyc();

    // Read 0x10: grant at T, data at T+1, response visible at T+2.
    rst = 1'b0;
    rd2(32'h10);
    smp();
    chk("rd_gnt", a.obi_a_gnt_o, 1);
    chk("rd_memreq", mem_req2, 1);
    chk("rd_memaddr", mem_addr2, 32'h10);
    chk("rd_memwe", mem_we2, 0);
    q2.push_back(32'hDEADBEEF);
    cyc();
    a.obi_a_req_i = 1'b0;
    smp(); chk("rd_valid_t1", a.obi_r_valid_o, 0);
    cyc();
    smp(); chk("rd_valid_t2", a.obi_r_valid_o, 1);
    cyc();

    // Write: pass-through in the grant cycle, zero response data.
    a.obi_a_req_i = 1'b1; a.obi_a_we_i = 1'b1; a.obi_a_addr_i = 32'h20;
    a.obi_a_wdata_i = 32'hCAFEF00D; a.obi_a_be_i = 4'b0011;
    smp();
    chk("wr_gnt", a.obi_a_gnt_o, 1);
    chk("wr_memwe", mem_we2, 1);
    chk("wr_membe", mem_be2, 4'b0011);
    chk("wr_memwdata", mem_wdata2, 32'hCAFEF00D);
    chk("wr_memaddr", mem_addr2, 32'h20);
    q2.push_back(32'h0);
    cyc();
    a.obi_a_req_i = 1'b0; a.obi_a_we_i = 1'b0; a.obi_a_be_i = 4'hF;
    cyc(); cyc(); cyc();

    // Backpressure: two grants, third held until the cycle after the first pop.
    a.obi_r_ready_i = 1'b0;
    rd2(32'h100); smp(); chk("bp_gnt0", a.obi_a_gnt_o, 1); q2.push_back(32'h5A5A0100); cyc();
    rd2(32'h104); smp(); chk("bp_gnt1", a.obi_a_gnt_o, 1); q2.push_back(32'h5A5A0104); cyc();
    rd2(32'h108);
    smp(); chk("bp_hold0", a.obi_a_gnt_o, 0); chk("bp_outs2", dut.outstanding, 2); cyc();
    smp(); chk("bp_hold1", a.obi_a_gnt_o, 0); chk("bp_valid", a.obi_r_valid_o, 1);
    chk("bp_head", a.obi_r_rdata_o, 32'h5A5A0100); cyc();
    smp(); chk("bp_stable_valid", a.obi_r_valid_o, 1);
    chk("bp_stable_head", a.obi_r_rdata_o, 32'h5A5A0100); cyc();
    a.obi_r_ready_i = 1'b1;
    smp(); chk("bp_pop_nobypass", a.obi_a_gnt_o, 0); cyc();
    smp(); chk("bp_gnt2", a.obi_a_gnt_o, 1); q2.push_back(32'h5A5A0108); cyc();
    a.obi_a_req_i = 1'b0;
    smp(); chk("sim_outs1", dut.outstanding, 1);
    cyc(); cyc(); cyc();

    // Mid-operation reset with two responses pending: they are discarded.
    a.obi_r_ready_i = 1'b0;
    rd2(32'h200); smp(); chk("mr_gnt0", a.obi_a_gnt_o, 1); cyc();
    rd2(32'h204); smp(); chk("mr_gnt1", a.obi_a_gnt_o, 1); cyc();
    a.obi_a_req_i = 1'b0; cyc();
    rst = 1'b1; rd2(32'h10);
    smp(); chk("mr_rst_gnt", a.obi_a_gnt_o, 0); chk("mr_rst_valid", a.obi_r_valid_o, 0); cyc();
    rst = 1'b0;
    smp();
    chk("mr_valid", a.obi_r_valid_o, 0);
    chk("mr_outs", dut.outstanding, 0);
    chk("mr_gnt", a.obi_a_gnt_o, 1);
    q2.push_back(32'hDEADBEEF);
    cyc();
    a.obi_a_req_i = 1'b0; a.obi_r_ready_i = 1'b1;
    cyc(); cyc(); cyc();

    // Throughput on the depth-3 instance: eight consecutive grants.
    for (int i = 0; i < 8; i++) begin
      b.obi_a_req_i = 1'b1; b.obi_a_addr_i = 32'h300 + 32'(4 * i);
      smp(); chk("thr_gnt", b.obi_a_gnt_o, 1);
      q3.push_back(thr_exp[i]);
      cyc();
    end
    b.obi_a_req_i = 1'b0;

    // Bounded drain of both scoreboards.
    for (int i = 0; i < 40; i++) begin
      if (q2.size() == 0 && q3.size() == 0) break;
      cyc();
    end
    cyc();
    chk("drain_q2", q2.size(), 0);
    chk("drain_q3", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
